// File: rtl/nyan_anim_seq.sv
// Animation sequencer: derives frame_start from vsync and advances sprite frame / scroll in vblank.
// Optional NYAN_ANIM_PINGPONG_EN: anim_frame bounces between 0 and NUM_FRAMES-1 instead of wrapping.
module nyan_anim_seq #(
  parameter int unsigned NUM_FRAMES      = 6,
  parameter int unsigned FRAME_IDX_WIDTH = 3,
  parameter int unsigned FRAMES_PER_STEP = 4,
  parameter int unsigned SCROLL_STEP     = 8,
  parameter int unsigned SCROLL_WRAP     = 640,
  parameter int unsigned SCROLL_WIDTH    = 10
) (
  input  logic                       px_clk,
  input  logic                       reset_n,
  input  logic                       vsync,
  input  logic                       enable,
  input  logic                       step_req,
  output logic                       frame_start,
  output logic                       anim_tick,
  output logic [FRAME_IDX_WIDTH-1:0] anim_frame,
  output logic [SCROLL_WIDTH-1:0]    scroll_x,
  output logic [15:0]                frame_count,
  output logic                       paused
);

  localparam int unsigned DIV_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned SUM_W = SCROLL_WIDTH + 1;

  typedef enum logic [1:0] {RUN, PAUSED, STEP_PENDING} state_t;

  state_t                     state, state_next;
  logic                       vsync_q;
  logic                       advance;
  logic [DIV_W-1:0]           div_cnt, div_next;
  logic [FRAME_IDX_WIDTH-1:0] frame_next;
  logic [SUM_W-1:0]           scroll_sum;
  logic [SCROLL_WIDTH-1:0]    scroll_next;

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q     <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      vsync_q     <= vsync;
      frame_start <= vsync_q & ~vsync;
      if (frame_start) frame_count <= frame_count + 16'd1;
    end
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RUN;
      paused <= 1'b0;
    end else begin
      state  <= state_next;
      paused <= (state_next != RUN);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:          if (!enable) state_next = PAUSED;
      PAUSED: begin
        if (enable)        state_next = RUN;
        else if (step_req) state_next = STEP_PENDING;
      end
      STEP_PENDING: begin
        if (frame_start)   state_next = enable ? RUN : PAUSED;
        else if (enable)   state_next = RUN;
      end
      default:             state_next = RUN;
    endcase
  end

  // Step decision uses the pre-edge state, so a RUN frame_start still advances when enable drops with it.
  always_comb begin
    advance  = 1'b0;
    div_next = div_cnt;
    if (frame_start) begin
      unique case (state)
        RUN: begin
          if (div_cnt == DIV_W'(FRAMES_PER_STEP - 1)) begin
            div_next = '0;
            advance  = 1'b1;
          end else begin
            div_next = div_cnt + DIV_W'(1);
          end
        end
        STEP_PENDING: advance = 1'b1;
        default:      advance = 1'b0;
      endcase
    end
  end

`ifdef NYAN_ANIM_PINGPONG_EN
  logic dir_up, dir_next;

  always_comb begin
    frame_next = anim_frame;
    dir_next   = dir_up;
    if (NUM_FRAMES > 1) begin
      if (dir_up) begin
        if (anim_frame == FRAME_IDX_WIDTH'(NUM_FRAMES - 1)) begin
          frame_next = anim_frame - FRAME_IDX_WIDTH'(1);
          dir_next   = 1'b0;
        end else begin
          frame_next = anim_frame + FRAME_IDX_WIDTH'(1);
        end
      end else begin
        if (anim_frame == '0) begin
          frame_next = FRAME_IDX_WIDTH'(1);
          dir_next   = 1'b1;
        end else begin
          frame_next = anim_frame - FRAME_IDX_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n)     dir_up <= 1'b1;
    else if (advance) dir_up <= dir_next;
  end
`else
  always_comb begin
    frame_next = (anim_frame == FRAME_IDX_WIDTH'(NUM_FRAMES - 1)) ? '0
                                                                   : anim_frame + FRAME_IDX_WIDTH'(1);
  end
`endif

  always_comb begin
    scroll_sum  = {1'b0, scroll_x} + SUM_W'(SCROLL_STEP);
    scroll_next = SCROLL_WIDTH'((scroll_sum >= SUM_W'(SCROLL_WRAP)) ? scroll_sum - SUM_W'(SCROLL_WRAP)
                                                                    : scroll_sum);
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      anim_tick  <= 1'b0;
      anim_frame <= '0;
      scroll_x   <= '0;
    end else begin
      div_cnt   <= div_next;
      anim_tick <= advance;
      if (advance) begin
        anim_frame <= frame_next;
        scroll_x   <= scroll_next;
      end
    end
  end

`ifndef SYNTHESIS
  logic fs_prev;

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) fs_prev <= 1'b0;
    else          fs_prev <= frame_start;
  end

  always_ff @(posedge px_clk) begin
    if (reset_n) begin
      assert (int'(anim_frame) < int'(NUM_FRAMES));
      assert (int'(scroll_x) < int'(SCROLL_WRAP));
      assert (!anim_tick || fs_prev);
      assert (!(frame_start && fs_prev));
    end
  end
`endif

endmodule

// File: tb/tb_nyan_anim_seq.sv
// Bench for nyan_anim_seq: directed phase table, hand-written pause/step/reset sequences, random run,
// all checked each cycle against a step-count reference model; a second instance covers FRAMES_PER_STEP=1, SCROLL_STEP=7.
module tb_nyan_anim_seq;

  localparam int NF    = 6;
  localparam int FIW   = 3;
  localparam int FPS   = 4;
  localparam int STEP  = 8;
  localparam int WRAP  = 640;
  localparam int SW    = 10;
  localparam int STEP2 = 7;

  logic           clk = 1'b0;
  logic           rst_n, vsync, enable, step_req;
  logic           frame_start, anim_tick, paused;
  logic           frame_start2, anim_tick2, paused2;
  logic [FIW-1:0] anim_frame, anim_frame2;
  logic [SW-1:0]  scroll_x, scroll_x2;
  logic [15:0]    frame_count, frame_count2;

  always #5 clk = ~clk;

  nyan_anim_seq #(
    .NUM_FRAMES(NF), .FRAME_IDX_WIDTH(FIW), .FRAMES_PER_STEP(FPS),
    .SCROLL_STEP(STEP), .SCROLL_WRAP(WRAP), .SCROLL_WIDTH(SW)
  ) dut (
    .px_clk(clk), .reset_n(rst_n), .vsync(vsync), .enable(enable), .step_req(step_req),
    .frame_start(frame_start), .anim_tick(anim_tick), .anim_frame(anim_frame),
    .scroll_x(scroll_x), .frame_count(frame_count), .paused(paused)
  );

  nyan_anim_seq #(
    .NUM_FRAMES(NF), .FRAME_IDX_WIDTH(FIW), .FRAMES_PER_STEP(1),
    .SCROLL_STEP(STEP2), .SCROLL_WRAP(WRAP), .SCROLL_WIDTH(SW)
  ) dut2 (
    .px_clk(clk), .reset_n(rst_n), .vsync(vsync), .enable(enable), .step_req(step_req),
    .frame_start(frame_start2), .anim_tick(anim_tick2), .anim_frame(anim_frame2),
    .scroll_x(scroll_x2), .frame_count(frame_count2), .paused(paused2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int tick_seen = 0;
  int fs_seen = 0;

  // Reference model: tracks frames and completed steps; outputs follow arithmetically from the step count.
  typedef enum {M_RUN, M_PAUSED, M_PEND} mmode_t;
  mmode_t m_mode;
  int     m_frames, m_steps, m_steps2, m_since;
  bit     m_fs, m_vprev, m_tick, m_tick2;

  function automatic int frame_of(int s);
`ifdef NYAN_ANIM_PINGPONG_EN
    int p;
    if (NF == 1) return 0;
    p = s % (2 * NF - 2);
    return (p < NF) ? p : 2 * NF - 2 - p;
`else
    return s % NF;
`endif
  endfunction

  task automatic model_reset();
    m_mode = M_RUN; m_frames = 0; m_steps = 0; m_steps2 = 0; m_since = 0;
    m_fs = 1'b0; m_vprev = 1'b1; m_tick = 1'b0; m_tick2 = 1'b0;
  endtask

  task automatic model_edge();
    bit fs_now;
    fs_now  = m_fs;
    m_tick  = 1'b0;
    m_tick2 = 1'b0;
    if (fs_now) begin
      m_frames++;
      if (m_mode == M_RUN) begin
        m_since++;
        if (m_since == FPS) begin m_since = 0; m_steps++; m_tick = 1'b1; end
        m_steps2++; m_tick2 = 1'b1;
      end else if (m_mode == M_PEND) begin
        m_steps++; m_steps2++; m_tick = 1'b1; m_tick2 = 1'b1;
      end
    end
    case (m_mode)
      M_RUN:    if (enable !== 1'b1) m_mode = M_PAUSED;
      M_PAUSED: if (enable === 1'b1) m_mode = M_RUN; else if (step_req === 1'b1) m_mode = M_PEND;
      default:  if (fs_now) m_mode = (enable === 1'b1) ? M_RUN : M_PAUSED;
                else if (enable === 1'b1) m_mode = M_RUN;
    endcase
    m_fs    = m_vprev && (vsync === 1'b0);
    m_vprev = (vsync === 1'b1);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    chk("frame_start",  32'(frame_start),  32'(m_fs));
    chk("anim_tick",    32'(anim_tick),    32'(m_tick));
    chk("anim_frame",   32'(anim_frame),   32'(frame_of(m_steps)));
    chk("scroll_x",     32'(scroll_x),     32'((m_steps * STEP) % WRAP));
    chk("frame_count",  32'(frame_count),  32'(m_frames % 65536));
    chk("paused",       32'(paused),       32'(m_mode != M_RUN));
    chk("frame_start2", 32'(frame_start2), 32'(m_fs));
    chk("anim_tick2",   32'(anim_tick2),   32'(m_tick2));
    chk("anim_frame2",  32'(anim_frame2),  32'(frame_of(m_steps2)));
    chk("scroll_x2",    32'(scroll_x2),    32'((m_steps2 * STEP2) % WRAP));
    chk("frame_count2", 32'(frame_count2), 32'(m_frames % 65536));
    chk("paused2",      32'(paused2),      32'(m_mode != M_RUN));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n === 1'b1) model_edge();
    #1;
    if (anim_tick === 1'b1) tick_seen++;
    if (frame_start === 1'b1) fs_seen++;
    check_cycle();
  endtask

  task automatic do_frame();
    vsync = 1'b0;
    tick();
    chk("fs_one_after_edge", 32'(frame_start), 32'd1);
    repeat (2) tick();
    vsync = 1'b1;
    repeat (5) tick();
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_anim_tick"},   32'(anim_tick),   32'd0);
    chk({tag, "_anim_frame"},  32'(anim_frame),  32'd0);
    chk({tag, "_scroll_x"},    32'(scroll_x),    32'd0);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    chk({tag, "_paused"},      32'(paused),      32'd0);
  endtask

  typedef struct {
    int en; int nfr; int exp_steps; int exp_scroll; int exp_scroll2;
    int exp_fcount; int exp_paused; int exp_ticks;
  } phase_t;

  phase_t tbl[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1,   8,  2,  16,  56,   8, 0,  2};
    tbl[1] = '{1,  88, 24, 192,  32,  96, 0, 22};
    tbl[2] = '{1, 224, 80,   0, 320, 320, 0, 56};
    tbl[3] = '{0,  10, 80,   0, 320, 330, 1,  0};
    tbl[4] = '{1,   4, 81,   8, 348, 334, 0,  1};

    rst_n = 1'b0; vsync = 1'b1; enable = 1'b1; step_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      enable = tbl[i].en[0];
      repeat (2) tick();
      tick_seen = 0;
      fs_seen = 0;
      repeat (tbl[i].nfr) do_frame();
      chk($sformatf("tbl%0d_anim_frame", i),  32'(anim_frame),  32'(frame_of(tbl[i].exp_steps)));
      chk($sformatf("tbl%0d_scroll_x", i),    32'(scroll_x),    32'(tbl[i].exp_scroll));
      chk($sformatf("tbl%0d_scroll_x2", i),   32'(scroll_x2),   32'(tbl[i].exp_scroll2));
      chk($sformatf("tbl%0d_frame_count", i), 32'(frame_count), 32'(tbl[i].exp_fcount));
      chk($sformatf("tbl%0d_paused", i),      32'(paused),      32'(tbl[i].exp_paused));
      chk($sformatf("tbl%0d_ticks", i),       32'(tick_seen),   32'(tbl[i].exp_ticks));
      chk($sformatf("tbl%0d_fs_pulses", i),   32'(fs_seen),     32'(tbl[i].nfr));
    end

    // Pause, then a 3-cycle step_req yields exactly one advance.
    enable = 1'b0;
    repeat (2) tick();
    chk("pause_paused", 32'(paused), 32'd1);
    step_req = 1'b1;
    repeat (3) tick();
    step_req = 1'b0;
    tick_seen = 0;
    do_frame();
    chk("step_ticks", 32'(tick_seen), 32'd1);
    chk("step_anim_frame", 32'(anim_frame), 32'(frame_of(82)));
    chk("step_scroll_x", 32'(scroll_x), 32'd16);
    chk("step_paused", 32'(paused), 32'd1);
    enable = 1'b1;
    repeat (2) tick();
    repeat (3) do_frame();
    chk("div_unchanged_frame", 32'(anim_frame), 32'(frame_of(82)));

    // enable drops in the same cycle as a stepping frame_start.
    vsync = 1'b0;
    tick();
    chk("simul_fs", 32'(frame_start), 32'd1);
    enable = 1'b0;
    tick();
    chk("simul_tick", 32'(anim_tick), 32'd1);
    chk("simul_paused", 32'(paused), 32'd1);
    chk("simul_anim_frame", 32'(anim_frame), 32'(frame_of(83)));
    chk("simul_scroll_x", 32'(scroll_x), 32'd24);
    vsync = 1'b1;
    repeat (4) tick();

    // Step up to anim_frame 3, leave a step pending, then reset.
    repeat (4) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      do_frame();
    end
    chk("pre_reset_frame", 32'(anim_frame), 32'd3);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    chk("pre_reset_pending", 32'(paused), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    enable = 1'b1;
    tick_seen = 0;
    repeat (3) do_frame();
    chk("post_reset_no_adv", 32'(tick_seen), 32'd0);
    do_frame();
    chk("post_reset_adv", 32'(tick_seen), 32'd1);
    chk("post_reset_frame", 32'(anim_frame), 32'(frame_of(1)));
    chk("post_reset_scroll", 32'(scroll_x), 32'd8);

    for (int c = 0; c < 800; c++) begin
      if (c % 25 == 0) enable = ($urandom_range(0, 2) != 0);
      step_req = ($urandom_range(0, 5) == 0);
      vsync = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nyan_anim_seq.md
Name: nyan_anim_seq

Overview:
- Animation sequencer directly downstream of the VGA sync generator.
- Watches the active-low vsync to derive one start-of-frame event per display frame.
- Divides frames into animation steps and produces the sprite frame index and horizontal scroll offset used by the pixel renderer.
- All updates land in vertical blanking, so no mid-frame tearing; supports pause and single-step for debug.

Parameters:
- NUM_FRAMES, 6, number of sprite animation frames (>=1).
- FRAME_IDX_WIDTH, 3, width of anim_frame; 2^FRAME_IDX_WIDTH >= NUM_FRAMES.
- FRAMES_PER_STEP, 4, display frames per animation step (>=1).
- SCROLL_STEP, 8, pixels added to scroll_x per step (< SCROLL_WRAP).
- SCROLL_WRAP, 640, scroll modulus (equals H_ACTIVE of the selected mode).
- SCROLL_WIDTH, 10, width of scroll_x; 2^SCROLL_WIDTH >= SCROLL_WRAP.

Ports:
- px_clk  input  1  pixel clock, same domain as the sync generator.
- reset_n  input  1  asynchronous, active-low reset.
- vsync  input  1  active-low vertical sync from the sync generator.
- enable  input  1  1 = run, 0 = pause animation.
- step_req  input  1  level request for one step while paused.
- frame_start  output  1  one-cycle pulse per display frame.
- anim_tick  output  1  one-cycle pulse in the first cycle new anim_frame/scroll_x are visible.
- anim_frame  output  FRAME_IDX_WIDTH  current sprite frame, range [0, NUM_FRAMES-1].
- scroll_x  output  SCROLL_WIDTH  current scroll offset, range [0, SCROLL_WRAP-1].
- frame_count  output  16  free-running display frame counter.
- paused  output  1  high in PAUSED or STEP_PENDING.

Behaviour:
- Reset (async assert, sync-to-px_clk release):
  - all outputs 0;
  - internal vsync_q = 1, div_cnt = 0, state = RUN.
- Edge detect:
  - vsync_q <= vsync each cycle.
  - Falling edge is vsync_q==1 && vsync==0 in cycle E.
  - frame_start is registered, high exactly in cycle E+1.
  - The first vsync low after reset counts as an edge.
- frame_count: increments at the clock edge closing any frame_start cycle, in every state; wraps 65535 -> 0.
- State machine (evaluated every cycle, registered):
  - RUN: enable==0 -> PAUSED.
  - PAUSED: enable==1 -> RUN; else step_req==1 -> STEP_PENDING.
  - STEP_PENDING: further step_req ignored; on frame_start perform one advance, then -> RUN if enable==1, else PAUSED. enable==1 without frame_start -> RUN; the pending step is dropped and RUN rules apply.
- Step decision at frame_start, using the pre-edge state:
  - RUN: if div_cnt == FRAMES_PER_STEP-1, set div_cnt=0 and advance; else div_cnt+1.
  - STEP_PENDING: advance; div_cnt unchanged.
  - PAUSED: no change.
  - FRAMES_PER_STEP==1 advances every frame.
- Simultaneous events: enable falling in the same cycle as frame_start still advances if the state is RUN.
- Advance (one clock edge):
  - anim_frame = (anim_frame == NUM_FRAMES-1) ? 0 : anim_frame+1.
  - sum = scroll_x + SCROLL_STEP computed in SCROLL_WIDTH+1 bits; scroll_x = (sum >= SCROLL_WRAP) ? sum-SCROLL_WRAP : sum.
  - anim_tick high for the single following cycle; latency from vsync falling edge to new values is 2 cycles.
- Outputs change only at advance edges; stable for the whole visible frame.
- paused output is registered from the next state, so it updates with the state.
- reset_n asserted mid-operation: immediate clear; a pending step is discarded.
- Simulation-only checks (ifndef SYNTHESIS):
  - anim_frame < NUM_FRAMES and scroll_x < SCROLL_WRAP at all times;
  - anim_tick only in the cycle after frame_start;
  - frame_start never high in two consecutive cycles.

Optional Feature:
- Macro: NYAN_ANIM_PINGPONG_EN.
- Defined: anim_frame bounces 0,1,..,N-1,N-2,..,1,0,1.. using a direction register (reset = up), with the direction flipping at each end. NUM_FRAMES==1 holds 0. scroll_x is unaffected.
- Not defined: wrap sequence as above, no direction register.

Test Plan:
- Reset, enable=1, defaults, 8 vsync falling edges -> frame_start 8 single-cycle pulses 2 cycles... each 1 cycle after its edge; frame_count=8; anim_tick twice; anim_frame=2, scroll_x=16.
- 24 steps (96 frames) -> anim_frame wraps 5->0 every 6 steps; scroll_x after 80 steps = 640 mod 640 = 0; SCROLL_STEP=7 run checks 637 -> 4.
- Pause and step:
  - enable=0 mid-run -> paused=1; 10 frames give no anim_tick while frame_count advances by 10.
  - Hold step_req 3 cycles -> exactly one advance at the next frame_start; div_cnt unchanged.
- enable dropped in the same cycle as a stepping frame_start -> the advance still occurs, then PAUSED.
- Assert reset_n low mid-frame with anim_frame=3 and a step pending -> outputs 0 immediately; no advance after release until FRAMES_PER_STEP edges.
- NYAN_ANIM_PINGPONG_EN defined, NUM_FRAMES=4, FRAMES_PER_STEP=1 -> anim_frame 1,2,3,2,1,0,1 on successive frames.
